esdi_serial_cmd_if: RTL and testbench

- Serial command/status engine of the ESDI drive emulator; sits directly behind the board top-level pin conditioning, inside the block design.
- Runs the bit-level ESDI transfer_req/transfer_ack handshake. Deserialises 17-bit host commands (16 data + odd parity) into parallel words for the command decoder.
- Serialises 16-bit configuration/status words plus parity back onto esdi_confstat_data.
- All ESDI inputs arrive already polarity-corrected (active-high).

---
 rtl/esdi_serial_cmd_if.sv | 233 +++++++++++++++++++++++
 tb/tb_esdi_serial_cmd_if.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/esdi_serial_cmd_if.sv
// ESDI serial command/status engine: synchronised transfer_req/ack handshake, 17-bit command
// deserialiser and status serialiser. Optional handshake watchdog: ESDI_HANDSHAKE_TIMEOUT_EN.
module esdi_serial_cmd_if #(
    parameter int SYNC_STAGES    = 2,
    parameter int ACK_DELAY      = 4,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        esdi_transfer_req,
    input  logic        esdi_command_data,
    input  logic        esdi_drive_selected,
    output logic        esdi_transfer_ack,
    output logic        esdi_confstat_data,
    output logic [15:0] cmd_data,
    output logic        cmd_perr,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    input  logic [15:0] resp_data,
    input  logic        resp_valid,
    output logic        resp_ready,
`ifdef ESDI_HANDSHAKE_TIMEOUT_EN
    output logic        hs_timeout,
`endif
    output logic        busy
);

    localparam int FILL_W = $clog2(SYNC_STAGES + 1);
    localparam int DLY_W  = (ACK_DELAY > 1) ? $clog2(ACK_DELAY) : 1;

    if (SYNC_STAGES < 2 || ACK_DELAY < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("esdi_serial_cmd_if: illegal parameter value");
    end

    typedef enum logic [2:0] {
        IDLE, C_ACK, C_WAIT_REQ, C_DELIVER, S_WAIT_REQ, S_SETUP, S_ACK
    } state_t;

    state_t state, state_nx;

    logic [SYNC_STAGES-1:0] req_sync, data_sync;
    logic [FILL_W-1:0]      fill_cnt;
    logic                   req_prev;
    logic                   req_s, data_s, req_rise;

    logic [4:0]       cnt, cnt_nx;
    logic [16:0]      cmd_sr, cmd_sr_nx;
    logic [16:0]      tx_sr, tx_sr_nx;
    logic             ack_q, ack_nx;
    logic             conf_q, conf_nx;
    logic             rready_q, rready_nx;
    logic [DLY_W-1:0] dly, dly_nx;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            req_sync  <= '0;
            data_sync <= '0;
        end else begin
            req_sync  <= {req_sync[SYNC_STAGES-2:0], esdi_transfer_req};
            data_sync <= {data_sync[SYNC_STAGES-2:0], esdi_command_data};
        end
    end

    assign req_s  = req_sync[SYNC_STAGES-1];
    assign data_s = data_sync[SYNC_STAGES-1];

    // req_prev stays high until the chains hold real pin samples, so a req already
    // high at reset release must fall and rise again before it counts as an edge.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            fill_cnt <= FILL_W'(SYNC_STAGES);
            req_prev <= 1'b1;
        end else if (fill_cnt != '0) begin
            fill_cnt <= fill_cnt - FILL_W'(1);
        end else begin
            req_prev <= req_s;
        end
    end

    assign req_rise = (fill_cnt == '0) && req_s && !req_prev;

`ifdef ESDI_HANDSHAKE_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd;
    logic            wd_expire;
    logic            timeout_nx;

    assign wd_expire = (state != IDLE) && (state != C_DELIVER) && (wd == '0);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wd         <= WD_W'(TIMEOUT_CYCLES - 1);
            hs_timeout <= 1'b0;
        end else begin
            hs_timeout <= timeout_nx;
            if (state_nx != state)
                wd <= WD_W'(TIMEOUT_CYCLES - 1);
            else if (wd != '0)
                wd <= wd - WD_W'(1);
        end
    end
`endif

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state    <= IDLE;
            cnt      <= '0;
            cmd_sr   <= '0;
            tx_sr    <= '0;
            ack_q    <= 1'b0;
            conf_q   <= 1'b0;
            rready_q <= 1'b0;
            dly      <= '0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            cmd_sr   <= cmd_sr_nx;
            tx_sr    <= tx_sr_nx;
            ack_q    <= ack_nx;
            conf_q   <= conf_nx;
            rready_q <= rready_nx;
            dly      <= dly_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        cmd_sr_nx = cmd_sr;
        tx_sr_nx  = tx_sr;
        ack_nx    = ack_q;
        conf_nx   = conf_q;
        rready_nx = 1'b0;
        dly_nx    = dly;
`ifdef ESDI_HANDSHAKE_TIMEOUT_EN
        timeout_nx = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (esdi_drive_selected) begin
                    if (resp_valid && !req_s) begin
                        rready_nx = 1'b1;
                        tx_sr_nx  = {resp_data, ~^resp_data};
                        cnt_nx    = '0;
                        state_nx  = S_WAIT_REQ;
                    end else if (req_rise) begin
                        cmd_sr_nx = {16'b0, data_s};
                        cnt_nx    = 5'd1;
                        ack_nx    = 1'b1;
                        state_nx  = C_ACK;
                    end
                end
            end
            C_ACK: begin
                if (!req_s) begin
                    ack_nx   = 1'b0;
                    state_nx = (cnt < 5'd17) ? C_WAIT_REQ : C_DELIVER;
                end
            end
            C_WAIT_REQ: begin
                if (req_rise) begin
                    cmd_sr_nx = {cmd_sr[15:0], data_s};
                    cnt_nx    = cnt + 5'd1;
                    ack_nx    = 1'b1;
                    state_nx  = C_ACK;
                end
            end
            C_DELIVER: begin
                if (cmd_ready) begin
                    cnt_nx   = '0;
                    state_nx = IDLE;
                end
            end
            S_WAIT_REQ: begin
                if (req_rise) begin
                    conf_nx  = tx_sr[16];
                    tx_sr_nx = {tx_sr[15:0], 1'b0};
                    cnt_nx   = cnt + 5'd1;
                    dly_nx   = DLY_W'(ACK_DELAY - 1);
                    state_nx = S_SETUP;
                end
            end
            S_SETUP: begin
                if (dly == '0) begin
                    ack_nx   = 1'b1;
                    state_nx = S_ACK;
                end else begin
                    dly_nx = dly - DLY_W'(1);
                end
            end
            S_ACK: begin
                if (!req_s) begin
                    ack_nx = 1'b0;
                    if (cnt == 5'd17) begin
                        conf_nx  = 1'b0;
                        cnt_nx   = '0;
                        state_nx = IDLE;
                    end else begin
                        state_nx = S_WAIT_REQ;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase

        // A finished command is still handed over even if the host deselects us.
        if (!esdi_drive_selected && state != C_DELIVER) begin
            state_nx  = IDLE;
            cnt_nx    = '0;
            ack_nx    = 1'b0;
            conf_nx   = 1'b0;
            rready_nx = 1'b0;
        end
`ifdef ESDI_HANDSHAKE_TIMEOUT_EN
        if (wd_expire) begin
            state_nx   = IDLE;
            cnt_nx     = '0;
            ack_nx     = 1'b0;
            conf_nx    = 1'b0;
            timeout_nx = 1'b1;
        end
`endif
    end

    assign esdi_transfer_ack  = ack_q & esdi_drive_selected;
    assign esdi_confstat_data = conf_q & esdi_drive_selected;
    assign cmd_data           = cmd_sr[16:1];
    assign cmd_valid          = (state == C_DELIVER);
    assign cmd_perr           = (state == C_DELIVER) && ~^cmd_sr;
    assign resp_ready         = rready_q;
    assign busy               = (state != IDLE);

endmodule

// File: tb/tb_esdi_serial_cmd_if.sv
// Randomised bench for esdi_serial_cmd_if: a behavioural host drives the handshake, a
// scoreboard queue holds expected commands/status bits and a monitor checks DUT outputs.
module tb_esdi_serial_cmd_if;
    localparam int SYNC = 2;
    localparam int DLY  = 4;
    localparam int TMO  = 100;
    localparam int M_NONE = 0, M_CMD = 1, M_STAT = 2;

    typedef struct packed {
        logic [15:0] data;
        logic        perr;
    } cmd_t;

    logic        aclk = 1'b0, aresetn = 1'b0;
    logic        req = 1'b0, cdata = 1'b0, sel = 1'b1, ready = 1'b0, rvalid = 1'b0;
    logic [15:0] rdata = 16'h0;
    logic        ack, conf, perr, cvalid, rready, busy;
    logic [15:0] cdat;
`ifdef ESDI_HANDSHAKE_TIMEOUT_EN
    logic        hs_timeout;
`endif

    int checks = 0, errors = 0;
    int cyc = 0, req_cyc = 0, fall_cyc = 0, mode = M_NONE, ready_mode = 0;
    int ready_pulses = 0, offers = 0;
    cmd_t exp_cmd[$];
    logic exp_bits[$];

    esdi_serial_cmd_if #(.SYNC_STAGES(SYNC), .ACK_DELAY(DLY), .TIMEOUT_CYCLES(TMO)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .esdi_transfer_req(req), .esdi_command_data(cdata), .esdi_drive_selected(sel),
        .esdi_transfer_ack(ack), .esdi_confstat_data(conf),
        .cmd_data(cdat), .cmd_perr(perr), .cmd_valid(cvalid), .cmd_ready(ready),
        .resp_data(rdata), .resp_valid(rvalid), .resp_ready(rready),
`ifdef ESDI_HANDSHAKE_TIMEOUT_EN
        .hs_timeout(hs_timeout),
`endif
        .busy(busy)
    );

    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    always @(posedge aclk) begin
        #1;
        case (ready_mode)
            0:       ready = 1'b0;
            1:       ready = 1'b1;
            default: ready = ($urandom_range(0, 2) == 0);
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    logic ack_prev = 1'b0, cv_prev = 1'b0, rdy_prev = 1'b0;
    always @(negedge aclk) begin
        cmd_t e;
        if (aresetn) begin
            if (ack && !ack_prev) begin
                if (mode == M_CMD) begin
                    check("cmd_ack_latency", cyc - req_cyc, SYNC + 1);
                end else if (mode == M_STAT) begin
                    check("stat_ack_latency", cyc - req_cyc, SYNC + 1 + DLY);
                    if (exp_bits.size() == 0) fail_now("stat_bit_unexpected");
                    else check("stat_bit", 32'(conf), 32'(exp_bits.pop_front()));
                end else begin
                    fail_now("spurious_ack");
                end
            end
            if (cv_prev) check("cmd_valid_hold", 32'(cvalid), 32'(!rdy_prev));
            else if (cvalid) check("cmd_valid_latency", cyc - fall_cyc, SYNC + 1);
            if (cvalid && ready) begin
                if (exp_cmd.size() == 0) begin
                    fail_now("cmd_unexpected");
                end else begin
                    e = exp_cmd.pop_front();
                    check("cmd_data", 32'(cdat), 32'(e.data));
                    check("cmd_perr", 32'(perr), 32'(e.perr));
                end
            end
            if (rready) ready_pulses++;
        end
        ack_prev = ack;
        cv_prev  = cvalid;
        rdy_prev = ready;
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic wait_ack(input logic level, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge aclk);
            if (ack === level) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s ack=%b wanted=%b (cycle %0d)", name, ack, level, cyc);
        end
        tick();
    endtask

    task automatic host_bit(input logic b);
        cdata   = b;
        req     = 1'b1;
        req_cyc = cyc;
        wait_ack(1'b1, "ack_rise_timeout");
        req      = 1'b0;
        fall_cyc = cyc;
        wait_ack(1'b0, "ack_fall_timeout");
    endtask

    // Sends the first n bits (MSB first) of {word, parity}; only full words are expected out.
    task automatic send_cmd(input logic [15:0] w, input logic p, input int n);
        logic [16:0] bits;
        bits = {w, p};
        if (n == 17) exp_cmd.push_back({w, ($countones(bits) % 2 == 0)});
        mode = M_CMD;
        for (int i = 16; i > 16 - n; i--) host_bit(bits[i]);
        mode = M_NONE;
    endtask

    task automatic offer_status(input logic [15:0] w);
        bit seen = 1'b0;
        for (int i = 15; i >= 0; i--) exp_bits.push_back(w[i]);
        exp_bits.push_back($countones(w) % 2 == 0);
        rdata  = w;
        rvalid = 1'b1;
        offers++;
        for (int i = 0; i < 20; i++) begin
            @(negedge aclk);
            if (rready) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) fail_now("resp_ready_timeout");
        tick();
        rvalid = 1'b0;
    endtask

    task automatic read_status(input int n);
        mode = M_STAT;
        repeat (n) host_bit(1'b0);
        mode = M_NONE;
    endtask

    task automatic wait_idle(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge aclk);
            if (!busy) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) fail_now(name);
        tick();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ack"}, 32'(ack), 0);
        check({tag, "_conf"}, 32'(conf), 0);
        check({tag, "_cmd_valid"}, 32'(cvalid), 0);
        check({tag, "_cmd_perr"}, 32'(perr), 0);
        check({tag, "_cmd_data"}, 32'(cdat), 0);
        check({tag, "_resp_ready"}, 32'(rready), 0);
        check({tag, "_busy"}, 32'(busy), 0);
    endtask

    initial begin
        int acks_seen;
        logic [15:0] w;
        repeat (3) @(posedge aclk);
        #1;
        check_all_zero("reset");
        aresetn = 1'b1;
        repeat (5) tick();

        // Command held by the decoder for 10 cycles before acceptance.
        ready_mode = 0;
        send_cmd(16'h0A5C, 1'b0, 17);
        repeat (10) tick();
        ready_mode = 1;
        wait_idle("deliver_timeout");
        ready_mode = 2;
        send_cmd(16'h0001, 1'b0, 17);
        wait_idle("deliver_timeout");

        offer_status(16'h8003);
        read_status(17);
        check("stat_done_busy", 32'(busy), 0);
        check("stat_done_conf", 32'(conf), 0);

        for (int k = 0; k < 10; k++) begin
            w = 16'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                send_cmd(w, 1'($urandom_range(0, 1)), 17);
                wait_idle("deliver_timeout");
            end else begin
                offer_status(w);
                read_status(17);
                check("stat_done_busy", 32'(busy), 0);
            end
        end

        // Deselect while bit 9 of a command is being acknowledged.
        send_cmd(16'h1234, 1'b1, 8);
        mode    = M_CMD;
        cdata   = 1'b1;
        req     = 1'b1;
        req_cyc = cyc;
        wait_ack(1'b1, "ack_rise_timeout");
        sel = 1'b0;
        #1;
        check("desel_ack_same_cycle", 32'(ack), 0);
        tick();
        check("desel_busy", 32'(busy), 0);
        req  = 1'b0;
        mode = M_NONE;
        sel  = 1'b1;
        repeat (5) tick();
        send_cmd(16'hFFFF, 1'b1, 17);
        wait_idle("deliver_timeout");

        // Asynchronous reset in the middle of a status transfer, req left high.
        offer_status(16'($urandom));
        read_status(5);
        mode    = M_STAT;
        req     = 1'b1;
        req_cyc = cyc;
        wait_ack(1'b1, "ack_rise_timeout");
        mode = M_NONE;
        #3;
        aresetn = 1'b0;
        #1;
        check_all_zero("midreset");
        exp_bits.delete();
        tick();
        aresetn   = 1'b1;
        acks_seen = 0;
        repeat (20) begin
            @(negedge aclk);
            if (ack) acks_seen++;
        end
        check("req_high_no_ack", acks_seen, 0);
        tick();
        req = 1'b0;
        repeat (5) tick();
        send_cmd(16'($urandom), 1'($urandom_range(0, 1)), 17);
        wait_idle("deliver_timeout");

`ifdef ESDI_HANDSHAKE_TIMEOUT_EN
        begin
            bit seen = 1'b0;
            mode    = M_CMD;
            req     = 1'b1;
            req_cyc = cyc;
            wait_ack(1'b1, "ack_rise_timeout");
            for (int i = 0; i < 3 * TMO; i++) begin
                @(negedge aclk);
                if (hs_timeout) begin
                    seen = 1'b1;
                    break;
                end
            end
            if (!seen) fail_now("hs_timeout_missing");
            check("timeout_cycles", cyc - (req_cyc + SYNC + 1), TMO);
            check("timeout_ack", 32'(ack), 0);
            check("timeout_busy", 32'(busy), 0);
            @(negedge aclk);
            check("timeout_pulse_width", 32'(hs_timeout), 0);
            tick();
            req  = 1'b0;
            mode = M_NONE;
            repeat (5) tick();
        end
`endif

        check("cmd_queue_drained", exp_cmd.size(), 0);
        check("stat_queue_drained", exp_bits.size(), 0);
        check("resp_ready_pulses", ready_pulses, offers);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
